// File: rtl/fsim_sequencer.sv
// fsim_sequencer: hardware stuck-at fault-simulation loop driving a golden/faulty CUT pair.
// Optional macro FSIM_FAULT_DROP_EN ends a fault's pattern walk at its first detection.
module fsim_sequencer #(
    parameter int IN_W    = 178,
    parameter int OUT_W   = 123,
    parameter int NUM_PAT = 124,
    parameter int NUM_FLT = 5350,
    parameter int SETTLE  = 2,
    localparam int PAT_AW = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
    localparam int FLT_AW = (NUM_FLT > 1) ? $clog2(NUM_FLT) : 1,
    localparam int DET_W  = $clog2(NUM_FLT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               pat_rd_en,
    output logic [PAT_AW-1:0]  pat_addr,
    input  logic [IN_W-1:0]    pat_data,
    output logic [IN_W-1:0]    cut_in,
    input  logic [OUT_W-1:0]   gold_out,
    input  logic [OUT_W-1:0]   fault_out,
    output logic               flt_inject,
    output logic [FLT_AW-1:0]  flt_idx,
    output logic               syn_valid,
    input  logic               syn_ready,
    output logic [NUM_PAT-1:0] syn_data,
    output logic [FLT_AW-1:0]  syn_flt_idx,
    output logic [DET_W-1:0]   det_count
);

    localparam int SC_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

`ifdef FSIM_FAULT_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, INJECT, FETCH, LOAD, APPLY, COMPARE, EMIT, RELEASE, DONE
    } seqState_t;

    seqState_t          state, stateNext;
    logic [PAT_AW-1:0]  pCnt;
    logic [SC_W-1:0]    settleCnt;
    logic [FLT_AW-1:0]  fltIdx;
    logic [DET_W-1:0]   detCount;
    logic [NUM_PAT-1:0] syndrome;
    logic [IN_W-1:0]    cutIn;
    logic               mismatch, lastPat, lastFlt, settled, walkEnd;

    assign mismatch = |(gold_out ^ fault_out);
    assign lastPat  = (pCnt == PAT_AW'(NUM_PAT - 1));
    assign lastFlt  = (fltIdx == FLT_AW'(NUM_FLT - 1));
    assign settled  = (settleCnt == SC_W'(SETTLE - 1));
    assign walkEnd  = lastPat || (DROP_EN && mismatch);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = INJECT;
            INJECT:  stateNext = FETCH;
            FETCH:   stateNext = LOAD;
            LOAD:    stateNext = APPLY;
            APPLY:   if (settled) stateNext = COMPARE;
            COMPARE: stateNext = walkEnd ? EMIT : FETCH;
            EMIT:    if (syn_ready) stateNext = RELEASE;
            RELEASE: stateNext = lastFlt ? DONE : INJECT;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        // abort outranks start and syn_ready; in IDLE it simply keeps the FSM idle
        if (abort) stateNext = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pCnt      <= '0;
            settleCnt <= '0;
            fltIdx    <= '0;
            detCount  <= '0;
            syndrome  <= '0;
            cutIn     <= '0;
        end else if (!abort) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        fltIdx   <= '0;
                        detCount <= '0;
                        syndrome <= '0;
                        pCnt     <= '0;
                    end
                end
                INJECT:  pCnt <= '0;
                LOAD: begin
                    cutIn     <= pat_data;
                    settleCnt <= '0;
                end
                APPLY:   if (!settled) settleCnt <= settleCnt + 1'b1;
                COMPARE: begin
                    syndrome[pCnt] <= mismatch;
                    if (!walkEnd) pCnt <= pCnt + 1'b1;
                end
                EMIT:    if (syn_ready && (syndrome != '0)) detCount <= detCount + 1'b1;
                RELEASE: begin
                    syndrome <= '0;
                    if (!lastFlt) fltIdx <= fltIdx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (state != IDLE) && (state != DONE);
    assign done        = (state == DONE);
    assign pat_rd_en   = (state == FETCH);
    assign pat_addr    = pCnt;
    assign cut_in      = cutIn;
    assign flt_inject  = (state == INJECT) || (state == FETCH) || (state == LOAD) ||
                         (state == APPLY) || (state == COMPARE) || (state == EMIT);
    assign flt_idx     = fltIdx;
    assign syn_valid   = (state == EMIT);
    assign syn_data    = syndrome;
    assign syn_flt_idx = fltIdx;
    assign det_count   = detCount;

endmodule

// File: tb/tb_fsim_sequencer.sv
// tb_fsim_sequencer: randomized self-checking bench with a behavioural CUT pair and dictionary model.
// Honours FSIM_FAULT_DROP_EN when computing expected syndromes and run latency.
module tb_fsim_sequencer;

    localparam int IN_W = 16, OUT_W = 8, NUM_PAT = 4, NUM_FLT = 3, SETTLE = 2;
    localparam int PAT_AW = 2, FLT_AW = 2, DET_W = 2;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, syn_ready = 1'b0;
    logic busy, done, pat_rd_en, flt_inject, syn_valid;
    logic [PAT_AW-1:0]  pat_addr;
    logic [IN_W-1:0]    pat_data = '0;
    logic [IN_W-1:0]    cut_in;
    logic [OUT_W-1:0]   gold_out, fault_out;
    logic [FLT_AW-1:0]  flt_idx, syn_flt_idx;
    logic [NUM_PAT-1:0] syn_data;
    logic [DET_W-1:0]   det_count;

    int passCnt = 0, totalCnt = 0;
    logic [IN_W-1:0]    patMem [NUM_PAT];
    logic [NUM_PAT-1:0] detTab [NUM_FLT];
    logic [PAT_AW-1:0]  tbPat = '0;
    logic               randReady = 1'b0, detectNow;
    logic [NUM_PAT-1:0] recSyn [$];
    logic [FLT_AW-1:0]  recFlt [$];
    logic [FLT_AW-1:0]  firstFlt;
    logic [DET_W-1:0]   firstDet;

    fsim_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_PAT(NUM_PAT), .NUM_FLT(NUM_FLT), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .pat_rd_en(pat_rd_en), .pat_addr(pat_addr), .pat_data(pat_data), .cut_in(cut_in),
        .gold_out(gold_out), .fault_out(fault_out), .flt_inject(flt_inject), .flt_idx(flt_idx),
        .syn_valid(syn_valid), .syn_ready(syn_ready), .syn_data(syn_data),
        .syn_flt_idx(syn_flt_idx), .det_count(det_count)
    );

    always #5 clk = ~clk;

    // Pattern memory: one-cycle read latency; remember which pattern was fetched
    always @(posedge clk) begin
        if (pat_rd_en) begin
            tbPat    <= pat_addr;
            pat_data <= patMem[pat_addr];
        end
    end

    // CUT pair: the faulty copy differs only for table-marked (fault, pattern) pairs with the right vector applied
    always_comb begin
        gold_out  = cut_in[OUT_W-1:0] ^ cut_in[IN_W-1:IN_W-OUT_W];
        detectNow = flt_inject && (int'(flt_idx) < NUM_FLT) && detTab[flt_idx][tbPat] &&
                    (cut_in == patMem[tbPat]);
        fault_out = detectNow ? (gold_out ^ (8'h01 << tbPat)) : gold_out;
    end

    always begin
        @(negedge clk); #1;
        if (rst_n && syn_valid && syn_ready) begin
            recSyn.push_back(syn_data);
            recFlt.push_back(syn_flt_idx);
        end
    end

    always @(posedge clk) if (randReady) begin #1; syn_ready = 1'($urandom_range(0, 1)); end

    function automatic logic [NUM_PAT-1:0] expSyn(input logic [NUM_PAT-1:0] d);
        logic [NUM_PAT-1:0] r;
        r = d;
`ifdef FSIM_FAULT_DROP_EN
        r = '0;
        for (int p = NUM_PAT - 1; p >= 0; p--) if (d[p]) r = NUM_PAT'(1) << p;
`endif
        return r;
    endfunction

    function automatic int patsApplied(input logic [NUM_PAT-1:0] d);
`ifdef FSIM_FAULT_DROP_EN
        for (int p = 0; p < NUM_PAT; p++) if (d[p]) return p + 1;
`endif
        return NUM_PAT;
    endfunction

    task automatic setTable(input logic [NUM_PAT-1:0] d0, input logic [NUM_PAT-1:0] d1,
                            input logic [NUM_PAT-1:0] d2);
        detTab[0] = d0; detTab[1] = d1; detTab[2] = d2;
        for (int i = 0; i < NUM_PAT; i++) patMem[i] = IN_W'($urandom);
    endtask

    task automatic pulseStart;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
    endtask

    // Returns cycles from the start-sampling edge until done is seen, or -1 on timeout
    task automatic runOnce(output int lat);
        lat = -1;
        recSyn.delete(); recFlt.delete();
        pulseStart();
        firstFlt = flt_idx; firstDet = det_count;
        for (int n = 1; n <= 3000; n++) begin
            if (done) begin lat = n; break; end
            @(negedge clk);
        end
    endtask

    task automatic checkRun(input string tag, input int lat, input bit checkLat);
        int expLat, expDet;
        expLat = 1; expDet = 0;
        for (int f = 0; f < NUM_FLT; f++) begin
            expLat += 3 + patsApplied(detTab[f]) * (3 + SETTLE);
            if (detTab[f] != '0) expDet++;
        end
        totalCnt++;
        if (lat <= 0) $display("FAIL %s done_timeout: got %0d expected >0", tag, lat); else passCnt++;
        if (checkLat) begin
            totalCnt++;
            if (lat !== expLat) $display("FAIL %s latency: got %0d expected %0d", tag, lat, expLat);
            else passCnt++;
        end
        totalCnt++;
        if (recSyn.size() !== NUM_FLT) $display("FAIL %s record_count: got %0d expected %0d", tag, recSyn.size(), NUM_FLT);
        else passCnt++;
        for (int f = 0; f < NUM_FLT && f < recSyn.size(); f++) begin
            totalCnt++;
            if (recSyn[f] !== expSyn(detTab[f]))
                $display("FAIL %s syn_data[%0d]: got %b expected %b", tag, f, recSyn[f], expSyn(detTab[f]));
            else passCnt++;
            totalCnt++;
            if (recFlt[f] !== FLT_AW'(f)) $display("FAIL %s syn_flt_idx[%0d]: got %0d expected %0d", tag, f, recFlt[f], f);
            else passCnt++;
        end
        totalCnt++;
        if (det_count !== DET_W'(expDet)) $display("FAIL %s det_count: got %0d expected %0d", tag, det_count, expDet);
        else passCnt++;
        totalCnt++;
        if (flt_idx !== FLT_AW'(NUM_FLT - 1)) $display("FAIL %s final_flt_idx: got %0d expected %0d", tag, flt_idx, NUM_FLT - 1);
        else passCnt++;
        @(negedge clk);
        totalCnt++;
        if ({busy, done} !== 2'b00) $display("FAIL %s post_done_idle: got busy/done %b expected 00", tag, {busy, done});
        else passCnt++;
        totalCnt++;
        if (det_count !== DET_W'(expDet)) $display("FAIL %s det_count_hold: got %0d expected %0d", tag, det_count, expDet);
        else passCnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        totalCnt++;
        if ({busy, done, pat_rd_en, flt_inject, syn_valid} !== 5'b0)
            $display("FAIL reset_flags: got %b expected 00000", {busy, done, pat_rd_en, flt_inject, syn_valid});
        else passCnt++;
        totalCnt++;
        if ({cut_in, pat_addr, flt_idx, syn_data, syn_flt_idx, det_count} !== '0)
            $display("FAIL reset_buses: got %h expected 0", {cut_in, pat_addr, flt_idx, syn_data, syn_flt_idx, det_count});
        else passCnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_no_detect;
        int lat;
        setTable(4'b0000, 4'b0000, 4'b0000);
        syn_ready = 1'b1;
        runOnce(lat);
        checkRun("no_detect", lat, 1'b1);
    endtask

    task automatic test_single_detect;
        int lat;
        setTable(4'b0000, 4'b0100, 4'b0000);
        runOnce(lat);
        checkRun("single_detect", lat, 1'b1);
    endtask

    task automatic test_pattern1_detect;
        int lat;
        setTable(4'b0010, 4'b0000, 4'b0000);
        runOnce(lat);
        checkRun("pattern1_detect", lat, 1'b1);
    endtask

    task automatic test_backpressure;
        logic [NUM_PAT-1:0] snapData;
        logic [FLT_AW-1:0]  snapIdx;
        bit found;
        setTable(4'b0010, 4'b0000, 4'b0000);
        syn_ready = 1'b0;
        pulseStart();
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (syn_valid) begin found = 1'b1; break; end
            @(negedge clk);
        end
        totalCnt++;
        if (!found) $display("FAIL bp_valid_timeout: got 0 expected 1"); else passCnt++;
        snapData = syn_data; snapIdx = syn_flt_idx;
        totalCnt++;
        if (snapData !== expSyn(detTab[0])) $display("FAIL bp_syn_data: got %b expected %b", snapData, expSyn(detTab[0]));
        else passCnt++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            totalCnt++;
            if (syn_valid !== 1'b1) $display("FAIL bp_valid_hold[%0d]: got %b expected 1", i, syn_valid); else passCnt++;
            totalCnt++;
            if ({syn_data, syn_flt_idx} !== {expSyn(detTab[0]), FLT_AW'(0)})
                $display("FAIL bp_stable[%0d]: got %b/%0d expected %b/0", i, syn_data, syn_flt_idx, expSyn(detTab[0]));
            else passCnt++;
            totalCnt++;
            if (flt_inject !== 1'b1) $display("FAIL bp_inject[%0d]: got %b expected 1", i, flt_inject); else passCnt++;
            totalCnt++;
            if (det_count !== '0) $display("FAIL bp_det_early[%0d]: got %0d expected 0", i, det_count); else passCnt++;
        end
        syn_ready = 1'b1;
        @(negedge clk);
        totalCnt++;
        if (det_count !== DET_W'(1)) $display("FAIL bp_det_after: got %0d expected 1", det_count); else passCnt++;
        totalCnt++;
        if ({syn_valid, flt_inject} !== 2'b00) $display("FAIL bp_release: got %b expected 00", {syn_valid, flt_inject});
        else passCnt++;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (done) begin found = 1'b1; break; end
            @(negedge clk);
        end
        totalCnt++;
        if (!found || det_count !== DET_W'(1)) $display("FAIL bp_finish: got done=%b det=%0d expected 1/1", found, det_count);
        else passCnt++;
        @(negedge clk);
    endtask

    task automatic test_random;
        int lat;
        for (int it = 0; it < 4; it++) begin
            setTable(NUM_PAT'($urandom), NUM_PAT'($urandom), NUM_PAT'($urandom));
            randReady = 1'b1;
            runOnce(lat);
            randReady = 1'b0;
            syn_ready = 1'b1;
            checkRun("random", lat, 1'b0);
        end
    endtask

    task automatic test_abort;
        int lat;
        bit found, sawDone;
        setTable(4'b1000, 4'b0000, 4'b0000);
        syn_ready = 1'b1;
        pulseStart();
        found = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (pat_rd_en && flt_idx == FLT_AW'(1)) begin found = 1'b1; break; end
            @(negedge clk);
        end
        totalCnt++;
        if (!found) $display("FAIL abort_reach_fault1: got 0 expected 1"); else passCnt++;
        @(negedge clk);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        totalCnt++;
        if ({busy, flt_inject, syn_valid, done} !== 4'b0000)
            $display("FAIL abort_outputs: got %b expected 0000", {busy, flt_inject, syn_valid, done});
        else passCnt++;
        totalCnt++;
        if (det_count !== DET_W'(1)) $display("FAIL abort_det_hold: got %0d expected 1", det_count); else passCnt++;
        sawDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) sawDone = 1'b1;
        end
        totalCnt++;
        if (sawDone) $display("FAIL abort_quiet: got activity 1 expected 0"); else passCnt++;
        setTable(4'b0000, 4'b0000, 4'b0001);
        runOnce(lat);
        totalCnt++;
        if ({firstFlt, firstDet} !== '0) $display("FAIL abort_restart: got flt=%0d det=%0d expected 0/0", firstFlt, firstDet);
        else passCnt++;
        checkRun("after_abort", lat, 1'b1);
    endtask

    task automatic test_reset_mid;
        int lat;
        bit found;
        setTable(4'b0001, 4'b0000, 4'b0000);
        syn_ready = 1'b1;
        pulseStart();
        found = 1'b0;
        for (int n = 0; n < 500; n++) begin
            if (pat_rd_en && flt_idx == FLT_AW'(1)) begin found = 1'b1; break; end
            @(negedge clk);
        end
        totalCnt++;
        if (!found || det_count !== DET_W'(1)) $display("FAIL rstmid_reach: got found=%b det=%0d expected 1/1", found, det_count);
        else passCnt++;
        repeat (4) @(negedge clk);
        recSyn.delete(); recFlt.delete();
        #2; rst_n = 1'b0; start = 1'b1;
        #1;
        totalCnt++;
        if ({busy, done, pat_rd_en, flt_inject, syn_valid} !== 5'b0)
            $display("FAIL rstmid_flags: got %b expected 00000", {busy, done, pat_rd_en, flt_inject, syn_valid});
        else passCnt++;
        totalCnt++;
        if ({cut_in, pat_addr, flt_idx, syn_data, syn_flt_idx, det_count} !== '0)
            $display("FAIL rstmid_buses: got %h expected 0", {cut_in, pat_addr, flt_idx, syn_data, syn_flt_idx, det_count});
        else passCnt++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            totalCnt++;
            if (busy !== 1'b0) $display("FAIL rstmid_start_ignored[%0d]: got %b expected 0", i, busy); else passCnt++;
        end
        start = 1'b0; rst_n = 1'b1;
        repeat (3) @(negedge clk);
        totalCnt++;
        if (busy !== 1'b0 || recSyn.size() !== 0) $display("FAIL rstmid_idle: got busy=%b records=%0d expected 0/0", busy, recSyn.size());
        else passCnt++;
        runOnce(lat);
        checkRun("after_reset", lat, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NUM_FLT; i++) detTab[i] = '0;
        for (int i = 0; i < NUM_PAT; i++) patMem[i] = '0;
        test_reset();
        test_no_detect();
        test_single_detect();
        test_pattern1_detect();
        test_backpressure();
        test_random();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/fsim_sequencer.md
Name: fsim_sequencer

Overview:
Synthesizable controller that runs the stuck-at fault-simulation loop in hardware on a gate-level CUT pair (golden copy and fault-injected copy). For each fault in the collapsed list it injects the fault, then walks every test pattern in pattern memory. It drives each pattern to both copies and compares their outputs to build a per-fault syndrome. It emits one dictionary record per fault and keeps a detected-fault count for coverage.

Parameters:
IN_W, 178, CUT primary-input width
OUT_W, 123, CUT primary-output width
NUM_PAT, 124, patterns per fault (syndrome width)
NUM_FLT, 5350, faults in collapsed list
SETTLE, 2, cycles allowed for CUT combinational settling (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a run when idle
abort  in  1  synchronous abort; returns to IDLE
busy  out  1  high from accepted start until done/abort
done  out  1  one-cycle pulse after last record accepted
pat_rd_en  out  1  pattern memory read strobe
pat_addr  out  clog2(NUM_PAT)  pattern index
pat_data  in  IN_W  read data, valid 1 cycle after pat_rd_en
cut_in  out  IN_W  registered vector driven to both CUT copies
gold_out  in  OUT_W  golden CUT outputs
fault_out  in  OUT_W  faulty CUT outputs
flt_inject  out  1  level; fault flt_idx active while high
flt_idx  out  clog2(NUM_FLT)  current fault index
syn_valid  out  1  dictionary record valid
syn_ready  in  1  consumer accepts record
syn_data  out  NUM_PAT  syndrome; bit p = pattern p detected
syn_flt_idx  out  clog2(NUM_FLT)  fault index of record
det_count  out  clog2(NUM_FLT+1)  faults with nonzero syndrome

Behaviour:
- Reset: all outputs 0, state IDLE, internal pattern counter 0.
- FSM states: IDLE, INJECT, FETCH, LOAD, APPLY, COMPARE, EMIT, RELEASE, DONE.
- IDLE:
  - start=1 -> INJECT.
  - On entry to INJECT: flt_idx=0, det_count=0, syndrome=0, busy=1.
  - start while busy is ignored.
- INJECT: flt_inject=1 for 1 cycle before any pattern, then FETCH with pattern counter p=0.
- FETCH: pat_rd_en=1, pat_addr=p for 1 cycle, then LOAD.
- LOAD: cut_in <= pat_data, then APPLY.
- APPLY: wait exactly SETTLE cycles, then COMPARE.
- COMPARE:
  - syndrome[p] <= |(gold_out ^ fault_out).
  - p==NUM_PAT-1 -> EMIT; otherwise p++ and -> FETCH.
  - Per-pattern cost: 3+SETTLE cycles.
- EMIT:
  - syn_valid=1; syn_data and syn_flt_idx are held stable until syn_ready.
  - On the handshake cycle: det_count++ if syndrome!=0, then -> RELEASE.
  - syn_ready asserted before syn_valid does not complete a handshake.
- RELEASE:
  - flt_inject=0 for 1 cycle (the fault is removed before the next index) and syndrome is cleared.
  - flt_idx==NUM_FLT-1 -> DONE; otherwise flt_idx++ and -> INJECT.
- DONE: done=1 for 1 cycle, busy=0 -> IDLE. det_count and flt_idx hold until the next start.
- abort (any non-IDLE state):
  - Next cycle: IDLE, flt_inject=0, syn_valid=0, busy=0, no done pulse.
  - det_count holds its partial value.
  - abort has priority over start and syn_ready.
- Asynchronous reset mid-run: immediate return to reset values. No record is emitted.
- cut_in holds its last value outside LOAD. The fault copy and golden copy therefore see identical stable inputs in APPLY/COMPARE.
- Counters never wrap: p is bounded by NUM_PAT-1, flt_idx by NUM_FLT-1, and det_count by NUM_FLT.

Optional Feature:
FSIM_FAULT_DROP_EN
- Defined: fault dropping. In COMPARE, a detection (XOR nonzero) sends the FSM directly to EMIT regardless of p. Remaining syndrome bits stay 0; det_count is unaffected.
- Undefined: every pattern is applied to every fault, giving a full dictionary.

Test Plan:
1. Params NUM_PAT=4, NUM_FLT=3, SETTLE=2; fault_out tied to gold_out; syn_ready=1; start -> three records, syn_data=4'b0000 each, det_count=0, done exactly 23*3+1 cycles after start (+/-1 per implementation-documented offset, fixed in bench).
2. Same params; bench forces fault_out!=gold_out only when flt_idx==1 and pat_addr latched==2 -> record for fault 1 shows syn_data=4'b0100, faults 0 and 2 show 0000, det_count=1.
3. syn_ready held 0 for 10 cycles during the first EMIT -> syn_valid stays 1 and syn_data/syn_flt_idx remain stable; flt_inject remains 1; det_count updates only on the handshake cycle.
4. abort asserted in APPLY of fault 1 -> next cycle busy=0, flt_inject=0, syn_valid=0, no done pulse; a new start then restarts at flt_idx=0 with det_count=0.
5. rst_n pulled low during COMPARE -> all outputs 0 asynchronously; after release, IDLE and start ignored until rst_n=1.
6. With FSIM_FAULT_DROP_EN and the mismatch on pattern 1 for fault 0 -> syn_data=4'b0010, fault 0 record appears 2*(3+SETTLE) cycles earlier than without the macro.
